// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the data-memory request channel between
// the memory pipeline stage and its responder.
package mem_bus_pkg;

    localparam int unsigned MemAddrW      = 16;
    localparam int unsigned MemDataW      = 16;
    localparam int unsigned MemDepth      = 256;
    localparam int unsigned MemWaitStates = 1;
    localparam int unsigned WaitCntW      = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StResp
    } rsp_state_e;

    typedef struct packed {
        logic                write;
        logic [MemAddrW-1:0] addr;
        logic [MemDataW-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/sram_array.sv
// Word-addressed storage array: synchronous write, synchronous registered read.
// Contents are deliberately never reset.
module sram_array #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the memory stage's load/store channel: captures one request,
// inserts programmable wait states, accesses the private array, returns one response.
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = MemAddrW,
    parameter int unsigned DATA_W      = MemDataW,
    parameter int unsigned DEPTH       = MemDepth,
    parameter int unsigned WAIT_STATES = MemWaitStates
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              busy
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);
    localparam logic [WaitCntW-1:0] WaitLoad =
        (WAIT_STATES > 0) ? WaitCntW'(WAIT_STATES - 1) : '0;

    rsp_state_e          state_q;
    logic [WaitCntW-1:0] cnt_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rsp_valid_q;
    logic                rsp_error_q;
    logic                rd_ok_q;
    logic                req_ready_q;
    logic                busy_q;

    logic              in_range;
    logic              arr_wr;
    logic              arr_rd;
    logic [DATA_W-1:0] arr_rdata;

    // Full-width compare so aliased high addresses never reach the array.
    assign in_range = ({1'b0, addr_q} < DepthLim);
    assign arr_wr   = (state_q == StAccess) && wr_q && in_range;
    assign arr_rd   = (state_q == StAccess) && !wr_q && in_range;

    sram_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IdxW)
    ) u_array (
        .clk   (clk),
        .wr_en (arr_wr),
        .rd_en (arr_rd),
        .addr  (addr_q[IdxW-1:0]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rd_ok_q     <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready_q) begin
                        wr_q        <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        rd_ok_q     <= 1'b0;
                        rsp_error_q <= 1'b0;
                        if (WAIT_STATES > 0) begin
                            state_q <= StWait;
                            cnt_q   <= WaitLoad;
                        end else begin
                            state_q <= StAccess;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StAccess;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StAccess: begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                    rsp_error_q <= !in_range;
                    rd_ok_q     <= !wr_q && in_range;
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        rsp_error_q <= 1'b0;
                        rd_ok_q     <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Array read register holds its value through RESP; zero it for stores/errors.
    assign rsp_rdata = rd_ok_q ? arr_rdata : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign req_ready = req_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed cases plus a random load/store stream
// checked against a plain array model, on a 1-wait-state and a 0-wait-state instance.
module tb_data_mem_responder;
    import mem_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, rsp_ready, sel;
    logic [15:0] req_addr, req_wdata;

    logic        rdy0, vld0, err0, bsy0, rdy1, vld1, err1, bsy1;
    logic [15:0] rd0, rd1;
    logic        cur_ready, cur_valid, cur_error, cur_busy;
    logic [15:0] cur_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] ref_mem [2][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.WAIT_STATES(1)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid && !sel),
        .req_ready (rdy0),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (vld0),
        .rsp_ready (sel ? 1'b1 : rsp_ready),
        .rsp_rdata (rd0),
        .rsp_error (err0),
        .busy      (bsy0)
    );

    data_mem_responder #(.WAIT_STATES(0)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid && sel),
        .req_ready (rdy1),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (vld1),
        .rsp_ready (sel ? rsp_ready : 1'b1),
        .rsp_rdata (rd1),
        .rsp_error (err1),
        .busy      (bsy1)
    );

    assign cur_ready = sel ? rdy1 : rdy0;
    assign cur_valid = sel ? vld1 : vld0;
    assign cur_error = sel ? err1 : err0;
    assign cur_busy  = sel ? bsy1 : bsy0;
    assign cur_rdata = sel ? rd1 : rd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts and ends at a negedge. Returns the cycle count seen just after the accept edge.
    task automatic do_req(input logic w, input int a, input logic [15:0] d, input int hold,
                          output int acc_cyc);
        int          k;
        int          ws;
        logic        exp_err;
        logic [15:0] exp_rd;
        ws      = sel ? 0 : 1;
        exp_err = (a >= 256);
        exp_rd  = (!w && !exp_err) ? ref_mem[sel][a] : 16'h0;
        k = 0;
        while (!cur_ready && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_wait", 32'(k < 30), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = 16'(a);
        req_wdata = d;
        rsp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        acc_cyc   = cyc;
        check("busy_after_accept", 32'(cur_busy), 32'd1);
        check("ready_after_accept", 32'(cur_ready), 32'd0);
        k = 0;
        while (!cur_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("rsp_latency", 32'(k), 32'(ws + 1));
        check("rsp_rdata", 32'(cur_rdata), 32'(exp_rd));
        check("rsp_error", 32'(cur_error), 32'(exp_err));
        if (w && !exp_err) ref_mem[sel][a] = d;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(cur_valid), 32'd1);
            check("hold_rdata", 32'(cur_rdata), 32'(exp_rd));
            check("hold_error", 32'(cur_error), 32'(exp_err));
            check("hold_ready", 32'(cur_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("consumed_valid", 32'(cur_valid), 32'd0);
        check("consumed_ready", 32'(cur_ready), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int       acc;
        int       prev;
        int       a;
        mem_req_t rq;
        reset     = 1'b0;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", 32'(cur_ready), 32'd1);
        check("reset_busy", 32'(cur_busy), 32'd0);
        check("reset_rsp_valid", 32'(cur_valid), 32'd0);
        check("reset_rsp_rdata", 32'(cur_rdata), 32'd0);
        check("reset_rsp_error", 32'(cur_error), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // One wait state: store then load back.
        do_req(1'b1, 16'h0010, 16'hBEEF, 0, acc);
        do_req(1'b0, 16'h0010, 16'h0000, 0, acc);
        do_req(1'b1, 16'h0000, 16'h5A5A, 0, acc);

        // Out-of-range load and store; store must not alias onto address 0.
        do_req(1'b0, 16'h0100, 16'h0000, 0, acc);
        do_req(1'b1, 16'h0100, 16'hDEAD, 0, acc);
        do_req(1'b0, 16'h0000, 16'h0000, 0, acc);
        do_req(1'b0, 16'hFFFF, 16'h0000, 2, acc);

        // Backpressure for 5 cycles.
        do_req(1'b0, 16'h0010, 16'h0000, 5, acc);

        // Reset during WAIT drops the pending store.
        do_req(1'b1, 16'h0005, 16'h1234, 0, acc);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0005;
        req_wdata = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("wait_busy", 32'(cur_busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_reset_ready", 32'(cur_ready), 32'd1);
        check("mid_reset_busy", 32'(cur_busy), 32'd0);
        check("mid_reset_valid", 32'(cur_valid), 32'd0);
        check("mid_reset_rdata", 32'(cur_rdata), 32'd0);
        check("mid_reset_error", 32'(cur_error), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_req(1'b0, 16'h0005, 16'h0000, 0, acc);

        // Zero wait states: back-to-back stores then loads, one accept every 3 cycles.
        sel = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 20 + i, 16'(16'h1100 + 16'(i * 16'h0101)), 0, acc);
        end
        do_req(1'b0, 20, 16'h0000, 0, prev);
        for (int i = 1; i < 4; i++) begin
            do_req(1'b0, 20 + i, 16'h0000, 0, acc);
            check("accept_spacing", 32'(acc - prev), 32'd3);
            prev = acc;
        end

        // Random stream with backpressure on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(negedge clk);
            for (int i = 0; i < 16; i++) do_req(1'b1, i, 16'($urandom), 0, acc);
            for (int i = 0; i < 40; i++) begin
                a = int'($urandom_range(0, 9));
                rq.write = (a < 4);
                rq.addr  = (a == 9) ? 16'(256 + $urandom_range(0, 300)) : 16'($urandom_range(0, 15));
                rq.wdata = 16'($urandom);
                do_req(rq.write, int'(rq.addr), rq.wdata, int'($urandom_range(0, 3)), acc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
